// File: rtl/rwb_pkg.sv
// Shared types, widths and helpers for the result write-back stage.
package rwb_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FINISH
  } rwb_state_t;

  // Negative two's-complement results clamp to zero; others pass through.
  function automatic logic [DATA_W-1:0] relu16(input logic [DATA_W-1:0] value);
    return value[DATA_W-1] ? '0 : value;
  endfunction

endpackage

// File: rtl/rwb_fifo.sv
// Synchronous FIFO buffering core results ahead of the output SRAM write port.
// Depth must be a power of two so the pointers wrap naturally.
module rwb_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wptr_q] <= push_data;
    end
  end

  assign pop_data = mem[rptr_q];
  assign full     = (count_q == CntW'(Depth));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/result_writeback.sv
// Result write-back: buffers core results and writes them to consecutive output SRAM addresses.
// Optional clamp of negative results to zero when RESULT_WRITEBACK_RELU_EN is defined.
module result_writeback
  import rwb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_results,
  output logic                  busy,
  output logic                  done,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_ready,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_data
);

  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;

  rwb_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  acc_cnt_q;
  logic [CNT_WIDTH-1:0]  wr_cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FifoCntW-1:0]   fifo_count;
  logic [DATA_WIDTH-1:0] wr_value;
  logic                  last_entry;
  logic                  start_accept;

  rwb_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DATA_WIDTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (res_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign res_ready = (state_q == ACTIVE) && (fifo_count < FifoCntW'(FIFO_DEPTH)) &&
                     (acc_cnt_q < num_q);
  assign fifo_push    = res_valid && res_ready;
  assign fifo_pop     = (state_q == ACTIVE) && !fifo_empty;
  assign last_entry   = (wr_cnt_q == num_q - CNT_WIDTH'(1));
  assign start_accept = (state_q == IDLE) && start;

`ifdef RESULT_WRITEBACK_RELU_EN
  // Clamp at pop so the FIFO keeps the raw core values.
  assign wr_value = DATA_WIDTH'(relu16(DATA_W'(fifo_rdata)));
`else
  assign wr_value = fifo_rdata;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_results == '0) ? FINISH : ACTIVE;
        end
      end
      ACTIVE: begin
        if (fifo_pop && last_entry) begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      num_q     <= '0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q <= state_d;
      // done trails FINISH by one cycle so the last write is visible before it.
      done_q  <= (state_q == FINISH);
      if (start_accept) begin
        base_q    <= base_addr;
        num_q     <= num_results;
        acc_cnt_q <= '0;
        wr_cnt_q  <= '0;
        busy_q    <= 1'b1;
      end else begin
        if (state_q == FINISH) begin
          busy_q <= 1'b0;
        end
        if (fifo_push) begin
          acc_cnt_q <= acc_cnt_q + CNT_WIDTH'(1);
        end
        if (fifo_pop) begin
          wr_cnt_q <= wr_cnt_q + CNT_WIDTH'(1);
        end
      end
      we_q <= fifo_pop;
      if (fifo_pop) begin
        waddr_q <= base_q + ADDR_WIDTH'(wr_cnt_q);
        wdata_q <= wr_value;
      end
    end
  end

  no_push_at_full: assert property (@(posedge clock) disable iff (reset)
                                    !(fifo_push && fifo_full));

  assign busy          = busy_q;
  assign done          = done_q;
  assign write_enable  = we_q;
  assign write_address = waddr_q;
  assign write_data    = wdata_q;

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: jobs, backpressure, zero count, wrap, reset and clamp.
module tb_result_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] base_addr;
  logic [11:0] num_results;
  logic        busy;
  logic        done;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready;
  logic        write_enable;
  logic [11:0] write_address;
  logic [15:0] write_data;

  int n_checks = 0;
  int n_fail   = 0;

  int          cyc = 0;
  int          busy_cycles = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [11:0] wa_q[$];
  logic [15:0] wd_q[$];
  int          wc_q[$];

  result_writeback dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .num_results   (num_results),
    .busy          (busy),
    .done          (done),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_ready     (res_ready),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (write_enable === 1'b1) begin
      wa_q.push_back(write_address);
      wd_q.push_back(write_data);
      wc_q.push_back(cyc);
    end
    if (busy === 1'b1) busy_cycles = busy_cycles + 1;
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    busy_cycles = 0;
    done_cnt    = 0;
    done_cyc    = 0;
  endtask

  task automatic do_start(input logic [11:0] b, input logic [11:0] n);
    start       = 1'b1;
    base_addr   = b;
    num_results = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] v, output bit ok);
    ok        = 1'b0;
    res_valid = 1'b1;
    res_data  = v;
    for (int i = 0; i < 50; i++) begin
      if (res_ready === 1'b1) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    res_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({busy, done, res_ready, write_enable} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got busy=%b done=%b ready=%b we=%b, want all 0",
               busy, done, res_ready, write_enable);
    end
    n_checks++;
    if (write_address !== 12'h000 || write_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_write_port: got addr=%h data=%h, want 000/0000",
               write_address, write_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    bit all_ok = 1'b1;
    clear_log();
    do_start(12'h000, 12'd4);
    for (int i = 0; i < 4; i++) begin
      send(16'(i + 1), ok);
      all_ok &= ok;
    end
    n_checks++;
    if (!all_ok) begin
      n_fail++;
      $display("FAIL basic_accept: a result was not accepted within bound");
    end
    wait_done(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: done never seen"); end
    n_checks++;
    if (wa_q.size() != 4) begin
      n_fail++;
      $display("FAIL basic_write_count: got %0d, want 4", wa_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (wa_q[i] !== 12'(i) || wd_q[i] !== 16'(i + 1) || wc_q[i] != wc_q[0] + i) begin
          n_fail++;
          $display("FAIL basic_write%0d: got (%h,%h) cyc %0d, want (%h,%h) cyc %0d", i,
                   wa_q[i], wd_q[i], wc_q[i], 12'(i), 16'(i + 1), wc_q[0] + i);
        end
      end
      n_checks++;
      if (done_cyc != wc_q[3] + 1) begin
        n_fail++;
        $display("FAIL basic_done_time: got cyc %0d, want %0d", done_cyc, wc_q[3] + 1);
      end
    end
    n_checks++;
    if (busy_cycles != 6 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL basic_busy_done: got busy %0d done %0d, want 6 and 1",
               busy_cycles, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int acc  = 0;
    int gaps = 0;
    bit rdy;
    clear_log();
    do_start(12'h000, 12'd8);
    for (int i = 0; i < 20 && acc < 8; i++) begin
      res_valid = 1'b1;
      res_data  = 16'h0010 + 16'(acc);
      rdy = res_ready;
      if (rdy !== 1'b1) gaps++;
      tick();
      if (rdy) acc++;
    end
    n_checks++;
    if (acc != 8 || gaps != 0) begin
      n_fail++;
      $display("FAIL bp_ready_continuous: got %0d accepted %0d gaps, want 8 and 0", acc, gaps);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (res_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready_after_count: got %b, want 0", res_ready);
      end
      tick();
    end
    res_valid = 1'b0;
    wait_done(ok);
    n_checks++;
    if (!ok || wa_q.size() != 8) begin
      n_fail++;
      $display("FAIL bp_writes: got done=%0b count %0d, want 1 and 8", ok, wa_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (wa_q[i] !== 12'(i) || wd_q[i] !== 16'h0010 + 16'(i) || wc_q[i] != wc_q[0] + i) begin
          n_fail++;
          $display("FAIL bp_write%0d: got (%h,%h) cyc %0d, want (%h,%h) cyc %0d", i,
                   wa_q[i], wd_q[i], wc_q[i], 12'(i), 16'h0010 + 16'(i), wc_q[0] + i);
        end
      end
    end
  endtask

  task automatic test_zero_count();
    clear_log();
    do_start(12'h123, 12'd0);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_first_cycle: got busy=%b done=%b, want 1/0", busy, done);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_second_cycle: got busy=%b done=%b, want 0/1", busy, done);
    end
    tick();
    tick();
    n_checks++;
    if (wa_q.size() != 0 || busy_cycles != 1 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_summary: got writes %0d busy %0d done %0d, want 0 1 1",
               wa_q.size(), busy_cycles, done_cnt);
    end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    logic [11:0] exp_a [4];
    exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000; exp_a[3] = 12'h001;
    clear_log();
    do_start(12'hFFE, 12'd4);
    for (int i = 0; i < 4; i++) send(16'h00A0 + 16'(i), ok);
    wait_done(ok);
    n_checks++;
    if (!ok || wa_q.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_writes: got done=%0b count %0d, want 1 and 4", ok, wa_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (wa_q[i] !== exp_a[i] || wd_q[i] !== 16'h00A0 + 16'(i)) begin
          n_fail++;
          $display("FAIL wrap_write%0d: got (%h,%h), want (%h,%h)", i, wa_q[i], wd_q[i],
                   exp_a[i], 16'h00A0 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    clear_log();
    do_start(12'h200, 12'd2);
    do_start(12'h300, 12'd5);
    send(16'h0111, ok);
    send(16'h0222, ok);
    res_valid = 1'b1;
    res_data  = 16'h0333;
    n_checks++;
    if (res_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_ready: got %b, want 0 after 2 results", res_ready);
    end
    res_valid = 1'b0;
    wait_done(ok);
    n_checks++;
    if (!ok || wa_q.size() != 2 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL ignore_count: got done=%0b writes %0d, want 1 and 2", ok, wa_q.size());
    end else begin
      n_checks++;
      if (wa_q[0] !== 12'h200 || wa_q[1] !== 12'h201 ||
          wd_q[0] !== 16'h0111 || wd_q[1] !== 16'h0222) begin
        n_fail++;
        $display("FAIL ignore_writes: got (%h,%h)(%h,%h), want (200,0111)(201,0222)",
                 wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    int nw = 0;
    clear_log();
    do_start(12'h100, 12'd10);
    for (int i = 0; i < 30 && nw < 3; i++) begin
      res_valid = 1'b1;
      res_data  = 16'h0500 + 16'(i);
      tick();
      if (write_enable === 1'b1) nw++;
    end
    reset     = 1'b1;
    res_valid = 1'b0;
    tick();
    n_checks++;
    if ({busy, done, res_ready, write_enable} !== 4'b0000 || write_address !== 12'h000 ||
        write_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy=%b done=%b rdy=%b we=%b a=%h d=%h, want 0",
               busy, done, res_ready, write_enable, write_address, write_data);
    end
    reset = 1'b0;
    tick();
    clear_log();
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (wa_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: got writes %0d busy %b, want 0 and 0", wa_q.size(), busy);
    end
    do_start(12'h050, 12'd2);
    send(16'h0AAA, ok);
    send(16'h0BBB, ok);
    wait_done(ok);
    n_checks++;
    if (!ok || wa_q.size() != 2) begin
      n_fail++;
      $display("FAIL midreset_newjob: got done=%0b writes %0d, want 1 and 2", ok, wa_q.size());
    end else begin
      n_checks++;
      if (wa_q[0] !== 12'h050 || wa_q[1] !== 12'h051 ||
          wd_q[0] !== 16'h0AAA || wd_q[1] !== 16'h0BBB) begin
        n_fail++;
        $display("FAIL midreset_writes: got (%h,%h)(%h,%h), want (050,0aaa)(051,0bbb)",
                 wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
      end
    end
  endtask

  task automatic test_relu();
    bit ok;
    logic [15:0] in_v [3];
    logic [15:0] exp_d [3];
    in_v[0] = 16'h8001; in_v[1] = 16'h0005; in_v[2] = 16'hFFFF;
`ifdef RESULT_WRITEBACK_RELU_EN
    exp_d[0] = 16'h0000; exp_d[1] = 16'h0005; exp_d[2] = 16'h0000;
`else
    exp_d[0] = 16'h8001; exp_d[1] = 16'h0005; exp_d[2] = 16'hFFFF;
`endif
    clear_log();
    do_start(12'h400, 12'd3);
    for (int i = 0; i < 3; i++) send(in_v[i], ok);
    wait_done(ok);
    n_checks++;
    if (!ok || wd_q.size() != 3) begin
      n_fail++;
      $display("FAIL relu_count: got done=%0b writes %0d, want 1 and 3", ok, wd_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (wd_q[i] !== exp_d[i] || wa_q[i] !== 12'h400 + 12'(i)) begin
          n_fail++;
          $display("FAIL relu_write%0d: got (%h,%h), want (%h,%h)", i, wa_q[i], wd_q[i],
                   12'h400 + 12'(i), exp_d[i]);
        end
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    base_addr   = '0;
    num_results = '0;
    res_valid   = 1'b0;
    res_data    = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_addr_wrap();
    test_start_ignored();
    test_reset_mid_job();
    test_relu();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
